// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/192/256 encryptor: one shared round datapath stepped once per clock,
// with valid/ready handshakes on the plaintext input and the ciphertext output.
module aes_round_sequencer #(
    parameter int unsigned KEY_W = 1920
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_data,
    input  logic [3:0]       i_nr,
    input  logic [KEY_W-1:0] i_expanded_key,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_data,
    output logic             o_busy,
    output logic             o_error
);
    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

    fsm_e         r_fsm;
    fsm_e         w_fsm_next;
    logic [127:0] r_state;
    logic [3:0]   r_nr;
    logic [3:0]   r_rnd;
    logic         r_error;
    logic [3:0]   w_rk_idx;
    logic         w_accept;
    logic         w_nr_ok;
    logic         w_last_round;
    logic [127:0] w_rk;
    logic [127:0] w_sr_vec;
    logic [127:0] w_mc_vec;
    logic [7:0]   w_sb [16];
    logic [7:0]   w_sr [16];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse as x^254 (square-and-multiply), then the affine map; 0 maps to 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign w_accept     = i_valid & o_ready;
    assign w_nr_ok      = (i_nr == 4'd10) || (i_nr == 4'd12) || (i_nr == 4'd14);
    assign w_last_round = (r_rnd == r_nr - 4'd1);

    always_comb begin
        unique case (r_fsm)
            StRound: w_rk_idx = r_rnd;
            StFinal: w_rk_idx = r_nr;
            default: w_rk_idx = 4'd0;
        endcase
    end

    always_comb begin
        w_rk = '0;
        for (int k = 0; k < 15; k++) begin
            if (w_rk_idx == 4'(k)) w_rk = i_expanded_key[KEY_W-1-128*k -: 128];
        end
    end

    // Byte i of the block sits at row i%4, column i/4; byte 0 is the MSB byte.
    always_comb begin
        w_sr_vec = '0;
        w_mc_vec = '0;
        for (int i = 0; i < 16; i++) w_sb[i] = sbox(r_state[127-8*i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
        end
        for (int i = 0; i < 16; i++) w_sr_vec[127-8*i -: 8] = w_sr[i];
        for (int c = 0; c < 4; c++) begin
            w_mc_vec[127-32*c -: 32] = mix_col(w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= StIdle;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            StIdle:  if (w_accept && w_nr_ok) w_fsm_next = StRound;
            StRound: if (w_last_round) w_fsm_next = StFinal;
            StFinal: w_fsm_next = StDone;
            StDone:  if (i_ready) w_fsm_next = StIdle;
            default: w_fsm_next = StIdle;
        endcase
    end

    always_comb begin
        o_ready = (r_fsm == StIdle);
        o_valid = (r_fsm == StDone);
        o_busy  = (r_fsm != StIdle);
        o_error = r_error;
        o_data  = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_nr    <= '0;
            r_rnd   <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_accept & ~w_nr_ok;
            unique case (r_fsm)
                StIdle: begin
                    if (w_accept && w_nr_ok) begin
                        r_state <= i_data ^ w_rk;
                        r_nr    <= i_nr;
                        r_rnd   <= 4'd1;
                    end
                end
                StRound: begin
                    r_state <= w_mc_vec ^ w_rk;
                    // Hold the counter on the last full round so it stays within 1..13.
                    if (!w_last_round) r_rnd <= r_rnd + 4'd1;
                end
                StFinal: r_state <= w_sr_vec ^ w_rk;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: FIPS-197 vectors, back-pressure, reset abort,
// illegal round counts and randomized blocks against a byte-matrix AES reference model.
module tb_aes_round_sequencer;
    localparam int KW = 1920;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b0;
    logic [127:0]   i_data = '0;
    logic [3:0]     i_nr = '0;
    logic [KW-1:0]  i_expanded_key = '0;
    logic           o_ready, o_valid, o_busy, o_error;
    logic [127:0]   o_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_log[$];
    logic [7:0] sbox_t [256];

    aes_round_sequencer #(.KEY_W(KW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_nr(i_nr), .i_expanded_key(i_expanded_key), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_busy(o_busy), .o_error(o_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // S-box from the generator-3 log/antilog walk of GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Unused round-key slots are filled with junk so a wrong key index shows up.
    function automatic logic [KW-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [KW-1:0] ek;
        for (int i = 0; i < 60; i++) w[i] = $urandom;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) ek[KW-1-32*i -: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [KW-1:0] ek,
                                                 input logic [3:0] nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [127:0] rk, res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
        for (int rd = 0; rd <= int'(nr); rd++) begin
            if (rd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c+r)%4]];
                s = t;
                if (rd != int'(nr)) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int r = 0; r < 4; r++)
                            t[r][c] = mul2(s[r][c]) ^ mul2(s[(r+1)%4][c]) ^ s[(r+1)%4][c]
                                    ^ s[(r+2)%4][c] ^ s[(r+3)%4][c];
                    end
                    s = t;
                end
            end
            rk = ek[KW-1-128*rd -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // Cycle-level model: idle / busy for nr edges after accept / done until i_ready.
    int           m_mode = 0;  // 0 idle, 1 busy, 2 done
    int           m_cnt = 0;
    logic         m_err = 1'b0;
    logic [127:0] m_exp = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_err  = 1'b0;
        end
        chk("o_valid", o_valid, m_mode == 2);
        chk("o_ready", o_ready, m_mode == 0);
        chk("o_busy", o_busy, m_mode != 0);
        chk("o_error", o_error, m_err);
        if (m_mode == 2) chk("o_data", o_data, m_exp);
        if (!rst) begin
            m_err = 1'b0;
            case (m_mode)
                0: if (i_valid) begin
                    if (i_nr inside {4'd10, 4'd12, 4'd14}) begin
                        m_exp  = ref_encrypt(i_data, i_expanded_key, i_nr);
                        m_cnt  = int'(i_nr);
                        m_mode = 1;
                        acc_log.push_back(cyc);
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = 2;
                end
                default: if (i_ready) m_mode = 0;
            endcase
        end
    end

    task automatic drive_noise();
        i_valid = 1'($urandom_range(0, 1));
        i_data  = {$urandom, $urandom, $urandom, $urandom};
        i_nr    = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        chk("accept_seen", got, 1'b1);
    endtask

    task automatic do_block(input logic [127:0] pt, input logic [255:0] key, input int nk,
                            input logic [3:0] nr_in, input int stall, input bit noise);
        bit got;
        int lat;
        i_expanded_key = expand(key, nk);
        i_data  = pt;
        i_nr    = nr_in;
        i_ready = 1'b0;
        i_valid = 1'b1;
        wait_accept(got);
        if (!got) return;
        if (!(nr_in inside {4'd10, 4'd12, 4'd14})) begin
            @(negedge clk);
            chk("err_pulse", o_error, 1'b1);
            chk("err_ready", o_ready, 1'b1);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("err_clear", o_error, 1'b0);
            chk("err_no_valid", o_valid, 1'b0);
            @(posedge clk);
            #1;
            return;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            got = o_valid;
            if (!got) begin
                @(posedge clk);
                #1;
                lat++;
                if (noise) drive_noise();
            end
        end
        chk("valid_seen", got, 1'b1);
        if (got) chk("latency", lat, nr_in);
        @(posedge clk);
        #1;
        for (int s = 0; s < stall; s++) begin
            if (noise) drive_noise();
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KW-1:0] ek;
        bit got;
        int nk;
        logic [3:0] nr;
        build_sbox();
        chk("sbox_00", sbox_t[8'h00], 8'h63);
        chk("sbox_01", sbox_t[8'h01], 8'h7c);
        chk("sbox_53", sbox_t[8'h53], 8'hed);
        chk("sbox_ff", sbox_t[8'hff], 8'h16);
        ek = expand(K1, 4);
        chk("model_rk10", ek[KW-1-128*10 -: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1", ref_encrypt(PT, ek, 4'd10), CT1);
        chk("model_c2", ref_encrypt(PT, expand(K2, 6), 4'd12), CT2);
        chk("model_c3", ref_encrypt(PT, expand(K3, 8), 4'd14), CT3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", o_ready, 1'b1);
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_error", o_error, 1'b0);
        chk("reset_data", o_data, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_block(PT, K1, 4, 4'd10, 0, 1'b0);
        do_block(PT, K2, 6, 4'd12, 0, 1'b0);
        do_block(PT, K3, 8, 4'd14, 0, 1'b0);
        do_block(PT, K1, 4, 4'd10, 20, 1'b1);

        // Back-to-back with i_valid and i_ready held high.
        acc_log.delete();
        i_expanded_key = expand(K1, 4);
        i_data  = PT;
        i_nr    = 4'd10;
        i_ready = 1'b1;
        i_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("b2b_accepts", acc_log.size(), 3);
        if (acc_log.size() >= 2) chk("b2b_gap", acc_log[1] - acc_log[0], 12);

        // Reset partway through the rounds, then resend.
        i_expanded_key = expand(K1, 4);
        i_data  = PT;
        i_nr    = 4'd10;
        i_valid = 1'b1;
        wait_accept(got);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", o_valid, 1'b0);
        chk("abort_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_block(PT, K1, 4, 4'd10, 0, 1'b0);

        do_block(PT, K1, 4, 4'd11, 0, 1'b0);

        for (int b = 0; b < 15; b++) begin
            nk = 4 + 2 * $urandom_range(0, 2);
            nr = 4'(nk + 6);
            if ($urandom_range(0, 4) == 0) begin
                do nr = 4'($urandom_range(0, 15)); while (nr inside {4'd10, 4'd12, 4'd14});
            end
            do_block({$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                     nk, nr, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
